// File: rtl/sha256_block_sequencer.sv
// Block sequencer for a single-block SHA-256 compression core: launches one compression per
// 512-bit block, carries the chaining value across blocks and returns the final digest.
module sha256_block_sequencer #(
  parameter int unsigned TIMEOUT = 128,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             blk_valid,
  output logic             blk_ready,
  input  logic [511:0]     blk_data,
  input  logic             blk_first,
  input  logic             blk_last,
  output logic             core_start,
  output logic [511:0]     core_block,
  output logic [255:0]     core_hin,
  input  logic             core_done,
  input  logic [255:0]     core_hout,
  output logic             digest_valid,
  input  logic             digest_ready,
  output logic [255:0]     digest,
  output logic             busy,
  output logic [CNT_W-1:0] blk_count,
  output logic             err_timeout,
  output logic             err_seq
);

  localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam int unsigned WdW = $clog2(TIMEOUT) + 1;
  // Counter is compared before its increment, so this value means "reaches TIMEOUT-1 now".
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 2);

  typedef enum logic [1:0] {StIdle, StStart, StWait, StDone} state_e;

  state_e           state_q, state_d;
  logic [511:0]     block_q, block_d;
  logic             last_q, last_d;
  logic [255:0]     chain_q, chain_d;
  logic [255:0]     digest_q, digest_d;
  logic             digest_valid_q, digest_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WdW-1:0]   wdog_q, wdog_d;
  logic             err_timeout_q, err_timeout_d;
  logic             err_seq_q, err_seq_d;
  logic             msg_open_q, msg_open_d;

  always_comb begin
    state_d        = state_q;
    block_d        = block_q;
    last_d         = last_q;
    chain_d        = chain_q;
    digest_d       = digest_q;
    digest_valid_d = digest_valid_q;
    cnt_d          = cnt_q;
    wdog_d         = wdog_q;
    err_timeout_d  = err_timeout_q;
    err_seq_d      = err_seq_q;
    msg_open_d     = msg_open_q;
    blk_ready      = 1'b0;
    core_start     = 1'b0;

    unique case (state_q)
      StIdle: begin
        blk_ready = 1'b1;
        if (blk_valid) begin
          block_d = blk_data;
          last_d  = blk_last;
          if (blk_first) begin
            // A first block always restarts, silently abandoning any open message.
            chain_d    = IV;
            cnt_d      = '0;
            msg_open_d = 1'b1;
            state_d    = StStart;
          end else if (msg_open_q) begin
            state_d = StStart;
          end else begin
            err_seq_d = 1'b1;
          end
        end
      end
      StStart: begin
        core_start = 1'b1;
        wdog_d     = '0;
        state_d    = StWait;
      end
      StWait: begin
        wdog_d = wdog_q + 1'b1;
        if (core_done) begin
          chain_d = core_hout;
          if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
          if (last_q) begin
            digest_d       = core_hout;
            digest_valid_d = 1'b1;
            msg_open_d     = 1'b0;
            state_d        = StDone;
          end else begin
            state_d = StIdle;
          end
        end else if (wdog_q == WdLast) begin
          err_timeout_d = 1'b1;
          msg_open_d    = 1'b0;
          chain_d       = IV;
          state_d       = StIdle;
        end
      end
      StDone: begin
        if (digest_ready) begin
          digest_valid_d = 1'b0;
          state_d        = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      block_q        <= '0;
      last_q         <= 1'b0;
      chain_q        <= IV;
      digest_q       <= '0;
      digest_valid_q <= 1'b0;
      cnt_q          <= '0;
      wdog_q         <= '0;
      err_timeout_q  <= 1'b0;
      err_seq_q      <= 1'b0;
      msg_open_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      block_q        <= block_d;
      last_q         <= last_d;
      chain_q        <= chain_d;
      digest_q       <= digest_d;
      digest_valid_q <= digest_valid_d;
      cnt_q          <= cnt_d;
      wdog_q         <= wdog_d;
      err_timeout_q  <= err_timeout_d;
      err_seq_q      <= err_seq_d;
      msg_open_q     <= msg_open_d;
    end
  end

  assign core_block   = block_q;
  assign core_hin     = chain_q;
  assign digest_valid = digest_valid_q;
  assign digest       = digest_q;
  assign busy         = (state_q != StIdle);
  assign blk_count    = cnt_q;
  assign err_timeout  = err_timeout_q;
  assign err_seq      = err_seq_q;

endmodule

// File: tb/tb_sha256_block_sequencer.sv
// Self-checking bench: behavioural SHA-256 core plus a message-level model of the sequencer,
// with literal known-answer digests and randomized multi-block traffic.
module tb_sha256_block_sequencer;

  localparam int unsigned TIMEOUT = 128;
  localparam int unsigned CNT_W   = 16;

  localparam logic [255:0] IV      = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_DIG = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] TWO_DIG = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [447:0] MSG2    = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
  localparam logic [511:0] TWO_B1  = {MSG2, 8'h80, 56'h0};
  localparam logic [511:0] TWO_B2  = {480'h0, 32'h000001c0};

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
    32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
    32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
    32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
    32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
    32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             blk_valid = 1'b0;
  logic             blk_ready;
  logic [511:0]     blk_data = '0;
  logic             blk_first = 1'b0;
  logic             blk_last = 1'b0;
  logic             core_start;
  logic [511:0]     core_block;
  logic [255:0]     core_hin;
  logic             core_done = 1'b0;
  logic [255:0]     core_hout = '0;
  logic             digest_valid;
  logic             digest_ready = 1'b1;
  logic [255:0]     digest;
  logic             busy;
  logic [CNT_W-1:0] blk_count;
  logic             err_timeout;
  logic             err_seq;

  sha256_block_sequencer #(
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .blk_valid   (blk_valid),
    .blk_ready   (blk_ready),
    .blk_data    (blk_data),
    .blk_first   (blk_first),
    .blk_last    (blk_last),
    .core_start  (core_start),
    .core_block  (core_block),
    .core_hin    (core_hin),
    .core_done   (core_done),
    .core_hout   (core_hout),
    .digest_valid(digest_valid),
    .digest_ready(digest_ready),
    .digest      (digest),
    .busy        (busy),
    .blk_count   (blk_count),
    .err_timeout (err_timeout),
    .err_seq     (err_seq)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0]  w [64];
    logic [31:0]  v [8];
    logic [31:0]  t1, t2, s0, s1;
    logic [255:0] res;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0   = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
      s1   = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
    for (int i = 0; i < 64; i++) begin
      t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25)) +
           ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[i] + w[i];
      t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22)) +
           ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) res[255-32*i -: 32] = hin[255-32*i -: 32] + v[i];
    return res;
  endfunction

  // Message-level model of what the sequencer must show.
  int               cyc = 0;
  logic [255:0]     m_chain = IV;
  logic             m_open = 1'b0;
  logic [CNT_W-1:0] m_count = '0;
  logic             m_err_seq = 1'b0;
  logic             m_err_to = 1'b0;
  logic             m_dv = 1'b0;
  logic [255:0]     m_digest = '0;
  logic             m_wait = 1'b0;
  logic             m_last = 1'b0;
  logic             done_apply = 1'b0;
  logic             dv_clear = 1'b0;
  int               exp_start_cyc = -1;
  logic [255:0]     exp_hin = '0;
  logic [511:0]     exp_block = '0;
  logic [255:0]     exp_hout = '0;
  int               to_cyc = -1;

  // Behavioural core and handshake control.
  int           core_lat = 64;
  logic         core_mute = 1'b0;
  int           done_cyc = -1;
  logic [255:0] cap_hin = '0;
  logic [511:0] cap_blk = '0;
  int           n_starts = 0;
  logic         dr_force = 1'b0;
  logic         dr_rand = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      m_chain = IV; m_open = 1'b0; m_count = '0; m_err_seq = 1'b0; m_err_to = 1'b0;
      m_dv = 1'b0; m_wait = 1'b0; done_apply = 1'b0; dv_clear = 1'b0; exp_start_cyc = -1;
    end else begin
      if (done_apply) begin
        m_chain = exp_hout;
        if (m_count != '1) m_count = m_count + 1'b1;
        m_wait = 1'b0;
        if (m_last) begin
          m_dv = 1'b1; m_digest = exp_hout; m_open = 1'b0;
        end
        done_apply = 1'b0;
      end
      if (dv_clear) begin
        m_dv = 1'b0; dv_clear = 1'b0;
      end
      if (m_wait && cyc == to_cyc) begin
        m_err_to = 1'b1; m_open = 1'b0; m_chain = IV; m_wait = 1'b0;
      end
      chk("core_start", core_start, cyc == exp_start_cyc);
      if (m_wait) begin
        chk("core_hin", core_hin, exp_hin);
        chk("core_block", core_block, exp_block);
      end
      chk("err_seq", err_seq, m_err_seq);
      chk("err_timeout", err_timeout, m_err_to);
      chk("blk_count", blk_count, m_count);
      chk("digest_valid", digest_valid, m_dv);
      if (m_dv) chk("digest", digest, m_digest);
      chk("busy", busy, m_wait || m_dv);
      chk("blk_ready", blk_ready, !(m_wait || m_dv));
      if (core_start) begin
        n_starts++;
        cap_hin = core_hin;
        cap_blk = core_block;
        to_cyc  = cyc + TIMEOUT;
        if (!core_mute) done_cyc = cyc + core_lat;
      end
      digest_ready = dr_force ? 1'b0 : (dr_rand ? 1'($urandom_range(0, 1)) : 1'b1);
      if (m_dv && digest_ready) dv_clear = 1'b1;
    end
    // The core keeps running through a reset, so a late done can still arrive.
    if (cyc == done_cyc) begin
      core_done = 1'b1;
      core_hout = sha_compress(cap_hin, cap_blk);
      if (m_wait && !reset) done_apply = 1'b1;
    end else begin
      core_done = 1'b0;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic void model_accept(input logic [511:0] d, input logic f, input logic l);
    logic go;
    go = 1'b0;
    if (f) begin
      m_chain = IV; m_count = '0; m_open = 1'b1; go = 1'b1;
    end else if (m_open) begin
      go = 1'b1;
    end else begin
      m_err_seq = 1'b1;
    end
    if (go) begin
      exp_start_cyc = cyc + 1;
      exp_hin       = m_chain;
      exp_block     = d;
      exp_hout      = sha_compress(m_chain, d);
      m_last        = l;
      m_wait        = 1'b1;
    end
  endfunction

  task automatic send_block(input logic [511:0] d, input logic f, input logic l);
    int n = 0;
    blk_data  = d;
    blk_first = f;
    blk_last  = l;
    blk_valid = 1'b1;
    while (!blk_ready && n < 1000) begin
      tick();
      n++;
    end
    chk("blk_accept_bound", blk_ready, 1'b1);
    if (blk_ready) begin
      @(posedge clk);
      #1;
      model_accept(d, f, l);
    end
    blk_valid = 1'b0;
  endtask

  task automatic get_digest(output logic [255:0] d);
    int n = 0;
    tick();
    while (!digest_valid && n < 600) begin
      tick();
      n++;
    end
    chk("digest_wait_bound", digest_valid, 1'b1);
    d = digest;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((m_wait || m_dv) && n < 1000) begin
      tick();
      n++;
    end
    chk("idle_wait_bound", m_wait || m_dv, 1'b0);
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_blk_ready"}, blk_ready, 1'b1);
    chk({tag, "_core_start"}, core_start, 1'b0);
    chk({tag, "_digest_valid"}, digest_valid, 1'b0);
    chk({tag, "_digest"}, digest, '0);
    chk({tag, "_blk_count"}, blk_count, '0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_err_timeout"}, err_timeout, 1'b0);
    chk({tag, "_err_seq"}, err_seq, 1'b0);
    chk({tag, "_core_hin"}, core_hin, IV);
  endtask

  logic [255:0] d;
  logic [511:0] rb;
  int           s0;

  initial begin
    chk("model_abc", sha_compress(IV, ABC_BLK), ABC_DIG);
    chk("model_two", sha_compress(sha_compress(IV, TWO_B1), TWO_B2), TWO_DIG);
    repeat (3) tick();
    check_reset_outputs("reset");
    reset = 1'b0;
    repeat (2) tick();

    // Single-block "abc".
    s0 = n_starts;
    send_block(ABC_BLK, 1'b1, 1'b1);
    tick();
    chk("abc_hin_iv", cap_hin, IV);
    get_digest(d);
    chk("abc_digest", d, ABC_DIG);
    chk("abc_count", blk_count, 1);
    chk("abc_one_start", n_starts - s0, 1);
    wait_idle();

    // Two-block message.
    send_block(TWO_B1, 1'b1, 1'b0);
    send_block(TWO_B2, 1'b0, 1'b1);
    tick();
    chk("two_hin_chain", cap_hin, sha_compress(IV, TWO_B1));
    get_digest(d);
    chk("two_digest", d, TWO_DIG);
    chk("two_count", blk_count, 2);
    wait_idle();

    // Digest backpressure.
    dr_force = 1'b1;
    send_block(ABC_BLK, 1'b1, 1'b1);
    get_digest(d);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_valid", digest_valid, 1'b1);
      chk("bp_digest", digest, ABC_DIG);
      chk("bp_blk_ready", blk_ready, 1'b0);
    end
    dr_force = 1'b0;
    tick();
    tick();
    chk("bp_release_valid", digest_valid, 1'b0);
    chk("bp_release_ready", blk_ready, 1'b1);
    wait_idle();

    // Watchdog: core never answers; exact timing is checked every cycle.
    core_mute = 1'b1;
    send_block(ABC_BLK, 1'b1, 1'b1);
    for (int n = 0; n < 300 && !err_timeout; n++) tick();
    chk("to_flag", err_timeout, 1'b1);
    chk("to_idle", busy, 1'b0);
    core_mute = 1'b0;
    send_block(ABC_BLK, 1'b1, 1'b1);
    get_digest(d);
    chk("to_then_abc", d, ABC_DIG);
    wait_idle();

    // Orphan non-first block.
    s0 = n_starts;
    send_block(TWO_B2, 1'b0, 1'b1);
    repeat (3) tick();
    chk("orphan_err_seq", err_seq, 1'b1);
    chk("orphan_no_start", n_starts - s0, 0);

    // First block arriving mid-message restarts from IV.
    send_block(TWO_B1, 1'b1, 1'b0);
    wait_idle();
    send_block(ABC_BLK, 1'b1, 1'b1);
    get_digest(d);
    chk("abort_digest", d, ABC_DIG);
    chk("abort_count", blk_count, 1);
    wait_idle();

    // Reset during WAIT.
    send_block(TWO_B1, 1'b1, 1'b0);
    repeat (20) tick();
    reset = 1'b1;
    #1;
    check_reset_outputs("rst_wait");
    repeat (2) tick();
    reset = 1'b0;
    repeat (80) tick();
    chk("late_done_count", blk_count, 0);
    send_block(ABC_BLK, 1'b1, 1'b1);
    get_digest(d);
    chk("rst_then_abc", d, ABC_DIG);
    wait_idle();

    // Randomized traffic: multi-block, aborted messages, orphans, random latency/backpressure.
    dr_rand = 1'b1;
    for (int m = 0; m < 25; m++) begin
      int  nb;
      bit  abandon;
      nb      = $urandom_range(1, 4);
      abandon = ($urandom_range(0, 5) == 0);
      if (!m_open && $urandom_range(0, 7) == 0) begin
        for (int i = 0; i < 16; i++) rb[32*i +: 32] = $urandom;
        send_block(rb, 1'b0, 1'b0);
      end
      for (int b = 0; b < nb; b++) begin
        for (int i = 0; i < 16; i++) rb[32*i +: 32] = $urandom;
        core_lat = $urandom_range(1, 100);
        send_block(rb, b == 0, (b == nb - 1) && !abandon);
        repeat ($urandom_range(0, 3)) tick();
      end
      wait_idle();
    end

    repeat (5) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
